// File: rtl/dp_bram_pkg.sv
// Shared definitions for dp_bram: read-during-write mode encodings and a clog2 helper.
package dp_bram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  localparam int unsigned ADDR_W = 32;

  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dp_bram_port.sv
// One dp_bram access port: byte-address range check, row decode and read-data output pipeline.
module dp_bram_port
  import dp_bram_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 8192,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       RD_LAT    = 1,
  parameter int unsigned       ROW_W     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ROW_W-1:0]  o_row,
  output logic              o_inrange,
  output logic [DATA_W-1:0] o_do,
  output logic              o_val,
  output logic              o_err
);

  localparam int unsigned     OFF_W = clog2(DATA_W / 8);
  localparam longint unsigned SPAN  = longint'(DEPTH) * longint'(DATA_W / 8);

  logic [ADDR_W-1:0] w_offset;
  logic [DATA_W-1:0] w_do1;
  logic              r_v1;
  logic              r_e1;
  logic              r_dv;

  always_comb begin
    w_offset  = i_addr - BASE_ADDR;
    o_row     = w_offset[OFF_W +: ROW_W];
    o_inrange = (i_addr >= BASE_ADDR) && (64'(w_offset) < SPAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
      r_dv <= 1'b0;
    end else begin
      r_v1 <= i_en;
      if (i_en) begin
        r_e1 <= !o_inrange;
        r_dv <= 1'b1;
      end
    end
  end

  // The RAM output register upstream has no reset; r_dv forces zero until the first access after reset.
  always_comb w_do1 = (r_dv && !r_e1) ? i_rdata : '0;

  if (RD_LAT == 2) begin : g_lat2
    logic              r_v2;
    logic              r_e2;
    logic [DATA_W-1:0] r_do2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v2  <= 1'b0;
        r_e2  <= 1'b0;
        r_do2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_e2  <= r_e1;
          r_do2 <= w_do1;
        end
      end
    end

    assign o_do  = r_do2;
    assign o_val = r_v2;
    assign o_err = r_e2;
  end else begin : g_lat1
    assign o_do  = w_do1;
    assign o_val = r_v1;
    assign o_err = r_e1;
  end

endmodule

// File: rtl/dp_bram.sv
// dp_bram: true dual-port byte-writable RAM with address range checking and 1/2-cycle read latency.
// Define DP_BRAM_COLLISION_DET_EN to add the coll / coll_cnt same-row collision monitor.
module dp_bram
  import dp_bram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8192,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RD_LAT    = 1,
  parameter int          RDW_MODE  = int'(READ_FIRST)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                enb,
  input  logic [DATA_W/8-1:0] wea,
  input  logic [DATA_W/8-1:0] web,
  input  logic [31:0]         addra,
  input  logic [31:0]         addrb,
  input  logic [DATA_W-1:0]   dia,
  input  logic [DATA_W-1:0]   dib,
  output logic [DATA_W-1:0]   doa,
  output logic [DATA_W-1:0]   dob,
  output logic                vala,
  output logic                valb,
  output logic                erra,
  output logic                errb
`ifdef DP_BRAM_COLLISION_DET_EN
  ,
  output logic                coll,
  output logic [15:0]         coll_cnt
`endif
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned ROW_W = clog2(DEPTH);
  localparam bit          WF    = (RDW_MODE == int'(WRITE_FIRST));

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_a;
  logic [DATA_W-1:0] r_rd_b;
  logic [ROW_W-1:0]  w_row_a;
  logic [ROW_W-1:0]  w_row_b;
  logic              w_inr_a;
  logic              w_inr_b;
  logic              w_wr_a;
  logic              w_wr_b;

  dp_bram_port #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR),
    .RD_LAT   (RD_LAT),
    .ROW_W    (ROW_W)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .i_en     (ena),
    .i_addr   (addra),
    .i_rdata  (r_rd_a),
    .o_row    (w_row_a),
    .o_inrange(w_inr_a),
    .o_do     (doa),
    .o_val    (vala),
    .o_err    (erra)
  );

  dp_bram_port #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR),
    .RD_LAT   (RD_LAT),
    .ROW_W    (ROW_W)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .i_en     (enb),
    .i_addr   (addrb),
    .i_rdata  (r_rd_b),
    .o_row    (w_row_b),
    .o_inrange(w_inr_b),
    .o_do     (dob),
    .o_val    (valb),
    .o_err    (errb)
  );

  assign w_wr_a = ena && w_inr_a;
  assign w_wr_b = enb && w_inr_b;

  // Port A byte writes follow port B's so A wins overlapping bytes; the read ports see the pre-edge
  // array, and write-first overlays only the port's own bytes onto that old row.
  always_ff @(posedge clk) begin
    if (ena) r_rd_a <= r_mem[w_row_a];
    if (enb) r_rd_b <= r_mem[w_row_b];
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_wr_b && web[i]) r_mem[w_row_b][i*8 +: 8] <= dib[i*8 +: 8];
      if (w_wr_a && wea[i]) r_mem[w_row_a][i*8 +: 8] <= dia[i*8 +: 8];
      if (WF && w_wr_a && wea[i]) r_rd_a[i*8 +: 8] <= dia[i*8 +: 8];
      if (WF && w_wr_b && web[i]) r_rd_b[i*8 +: 8] <= dib[i*8 +: 8];
    end
  end

`ifdef DP_BRAM_COLLISION_DET_EN
  logic        w_coll;
  logic        r_coll;
  logic [15:0] r_coll_cnt;

  assign w_coll = ena && enb && w_inr_a && w_inr_b && (w_row_a == w_row_b) && ((|wea) || (|web));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coll     <= 1'b0;
      r_coll_cnt <= '0;
    end else begin
      r_coll <= w_coll;
      if (w_coll && (r_coll_cnt != '1)) r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end

  assign coll     = r_coll;
  assign coll_cnt = r_coll_cnt;
`endif

endmodule

// File: tb/tb_dp_bram.sv
// Self-checking bench for dp_bram: a read-first RD_LAT=1 instance and a write-first RD_LAT=2 instance share stimulus.
module tb_dp_bram;

  localparam int unsigned DEPTH = 8192;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        rst;
  logic        ena, enb;
  logic [3:0]  wea, web;
  logic [31:0] addra, addrb, dia, dib;
  logic [31:0] doa0, dob0, doa1, dob1;
  logic        vala0, valb0, erra0, errb0, vala1, valb1, erra1, errb1;
`ifdef DP_BRAM_COLLISION_DET_EN
  logic        coll0, coll1;
  logic [15:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_bram #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .RD_LAT(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dia(dia), .dib(dib), .doa(doa0), .dob(dob0),
    .vala(vala0), .valb(valb0), .erra(erra0), .errb(errb0)
`ifdef DP_BRAM_COLLISION_DET_EN
    , .coll(coll0), .coll_cnt(cnt0)
`endif
  );

  dp_bram #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .RD_LAT(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dia(dia), .dib(dib), .doa(doa1), .dob(dob1),
    .vala(vala1), .valb(valb1), .erra(erra1), .errb(errb1)
`ifdef DP_BRAM_COLLISION_DET_EN
    , .coll(coll1), .coll_cnt(cnt1)
`endif
  );

  typedef struct {
    logic ea; logic [3:0] wa; logic [31:0] aa; logic [31:0] da;
    logic eb; logic [3:0] wb; logic [31:0] ab; logic [31:0] db;
    logic ca; logic [31:0] xa; logic ka;
    logic cb; logic [31:0] xb; logic kb;
    logic kc;
  } vec_t;

  vec_t tbl[17];

  // Reference model state: memory rows with known contents, and dut1's previous-cycle expectations.
  logic [31:0] mm [int unsigned];
  int          ncoll = 0;
  logic        p_ea = 1'b0, p_eb = 1'b0, p_ia = 1'b0, p_ib = 1'b0, p_ka = 1'b0, p_kb = 1'b0;
  logic [31:0] p_fa = '0, p_fb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ea, input logic [3:0] wa, input logic [31:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [31:0] ab, input logic [31:0] db);
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
  endtask

  function automatic vec_t V(input logic ea, input logic [3:0] wa, input logic [31:0] aa, input logic [31:0] da,
                             input logic eb, input logic [3:0] wb, input logic [31:0] ab, input logic [31:0] db,
                             input logic ca, input logic [31:0] xa, input logic ka,
                             input logic cb, input logic [31:0] xb, input logic kb, input logic kc);
    vec_t v;
    v.ea = ea; v.wa = wa; v.aa = aa; v.da = da; v.eb = eb; v.wb = wb; v.ab = ab; v.db = db;
    v.ca = ca; v.xa = xa; v.ka = ka; v.cb = cb; v.xb = xb; v.kb = kb; v.kc = kc;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic wr_model(input int unsigned r, input logic [31:0] d, input logic [3:0] we);
    if (we == 4'h0) return;
    if (mm.exists(r)) mm[r] = merge(mm[r], d, we);
    else if (we == 4'hF) mm[r] = d;
  endtask

  // One scoreboarded cycle: dut0 is checked against this access, dut1 against the previous one.
  task automatic rstep(input logic ea, input logic [3:0] wa, input logic [31:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [31:0] ab, input logic [31:0] db);
    logic ia, ib, ka, kb, kfa, kfb, c;
    int unsigned ra, rb;
    logic [31:0] oa, ob, fa, fb;
    drive(ea, wa, aa, da, eb, wb, ab, db);
    @(posedge clk);
    ia = aa < SPAN;  ib = ab < SPAN;
    ra = aa / 4;     rb = ab / 4;
    ka = !ia || mm.exists(ra);
    kb = !ib || mm.exists(rb);
    oa = (ia && mm.exists(ra)) ? mm[ra] : 32'h0;
    ob = (ib && mm.exists(rb)) ? mm[rb] : 32'h0;
    fa = ia ? merge(oa, da, wa) : 32'h0;
    fb = ib ? merge(ob, db, wb) : 32'h0;
    kfa = ka || (wa == 4'hF);
    kfb = kb || (wb == 4'hF);
    c = ea && eb && ia && ib && (ra == rb) && ((wa != 4'h0) || (wb != 4'h0));
    if (eb && ib) wr_model(rb, db, wb);
    if (ea && ia) wr_model(ra, da, wa);
    if (c) ncoll++;
    #1;
    chk("rnd vala0", vala0, ea);
    chk("rnd valb0", valb0, eb);
    if (ea) chk("rnd erra0", erra0, !ia);
    if (eb) chk("rnd errb0", errb0, !ib);
    if (ea && ka) chk("rnd doa0", doa0, oa);
    if (eb && kb) chk("rnd dob0", dob0, ob);
    chk("rnd vala1", vala1, p_ea);
    chk("rnd valb1", valb1, p_eb);
    if (p_ea) chk("rnd erra1", erra1, !p_ia);
    if (p_eb) chk("rnd errb1", errb1, !p_ib);
    if (p_ea && p_ka) chk("rnd doa1", doa1, p_fa);
    if (p_eb && p_kb) chk("rnd dob1", dob1, p_fb);
`ifdef DP_BRAM_COLLISION_DET_EN
    chk("rnd coll0", coll0, c);
    chk("rnd coll1", coll1, c);
`endif
    p_ea = ea; p_eb = eb; p_ia = ia; p_ib = ib; p_ka = kfa; p_kb = kfb; p_fa = fa; p_fb = fb;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 15);
    if (k == 0) return 32'h8000 + 32'($urandom_range(0, 255) * 4);
    if (k == 1) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] rand_we();
    return ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst doa0", doa0, 0);  chk("rst dob0", dob0, 0);
    chk("rst vala0", vala0, 0); chk("rst valb0", valb0, 0);
    chk("rst erra0", erra0, 0); chk("rst errb0", errb0, 0);
    chk("rst doa1", doa1, 0);  chk("rst vala1", vala1, 0);
    chk("rst dob1", dob1, 0);  chk("rst valb1", valb1, 0);
`ifdef DP_BRAM_COLLISION_DET_EN
    chk("rst coll_cnt0", cnt0, 0);
    chk("rst coll0", coll0, 0);
`endif
    rst = 1'b0;
    tick();

    tbl[0]  = V(1, 4'hF, 32'h10,   32'hDEADBEEF, 0, 4'h0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0);
    tbl[1]  = V(0, 4'h0, 32'h0,    32'h0,        1, 4'h0, 32'h10,     32'h0,        0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 0);
    tbl[2]  = V(1, 4'hF, 32'h10,   32'h11223344, 0, 4'h0, 32'h0,      32'h0,        1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0);
    tbl[3]  = V(1, 4'h2, 32'h10,   32'h0000AA00, 0, 4'h0, 32'h0,      32'h0,        1, 32'h11223344, 0, 1, 32'hDEADBEEF, 0, 0);
    tbl[4]  = V(1, 4'h0, 32'h10,   32'h0,        1, 4'h0, 32'h10,     32'h0,        1, 32'h1122AA44, 0, 1, 32'h1122AA44, 0, 0);
    tbl[5]  = V(1, 4'hF, 32'h20,   32'hAAAAAAAA, 1, 4'hF, 32'h20,     32'h55555555, 0, 32'h0,        0, 0, 32'h0,        0, 1);
    tbl[6]  = V(1, 4'h0, 32'h20,   32'h0,        1, 4'h0, 32'h20,     32'h0,        1, 32'hAAAAAAAA, 0, 1, 32'hAAAAAAAA, 0, 0);
    tbl[7]  = V(1, 4'h3, 32'h20,   32'h00001111, 1, 4'hE, 32'h20,     32'h22222200, 1, 32'hAAAAAAAA, 0, 1, 32'hAAAAAAAA, 0, 1);
    tbl[8]  = V(1, 4'h0, 32'h20,   32'h0,        1, 4'h0, 32'h23,     32'h0,        1, 32'h22221111, 0, 1, 32'h22221111, 0, 0);
    tbl[9]  = V(1, 4'hF, 32'h10,   32'hCAFEF00D, 1, 4'h0, 32'h10,     32'h0,        1, 32'h1122AA44, 0, 1, 32'h1122AA44, 0, 1);
    tbl[10] = V(1, 4'h0, 32'h13,   32'h0,        1, 4'h0, 32'h10,     32'h0,        1, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 0, 0);
    tbl[11] = V(1, 4'hF, 32'h0,    32'h12345678, 1, 4'hF, 32'h7FFC,   32'h0BADC0DE, 0, 32'h0,        0, 0, 32'h0,        0, 0);
    tbl[12] = V(1, 4'h0, 32'h8000, 32'h0,        1, 4'h0, 32'h7FFC,   32'h0,        1, 32'h0,        1, 1, 32'h0BADC0DE, 0, 0);
    tbl[13] = V(1, 4'hF, 32'h8000, 32'hFFFFFFFF, 1, 4'hF, 32'hFFFFFFFC, 32'h0,      1, 32'h0,        1, 1, 32'h0,        1, 0);
    tbl[14] = V(1, 4'h0, 32'h0,    32'h0,        1, 4'h0, 32'h7FFC,   32'h0,        1, 32'h12345678, 0, 1, 32'h0BADC0DE, 0, 0);
    tbl[15] = V(0, 4'hF, 32'h0,    32'hFFFFFFFF, 0, 4'hF, 32'h7FFC,   32'h0,        1, 32'h12345678, 0, 1, 32'h0BADC0DE, 0, 0);
    tbl[16] = V(1, 4'h0, 32'h0,    32'h0,        1, 4'h0, 32'h7FFC,   32'h0,        1, 32'h12345678, 0, 1, 32'h0BADC0DE, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].ea, tbl[i].wa, tbl[i].aa, tbl[i].da, tbl[i].eb, tbl[i].wb, tbl[i].ab, tbl[i].db);
      tick();
      chk($sformatf("tbl%0d vala", i), vala0, tbl[i].ea);
      chk($sformatf("tbl%0d valb", i), valb0, tbl[i].eb);
      if (tbl[i].ea) chk($sformatf("tbl%0d erra", i), erra0, tbl[i].ka);
      if (tbl[i].eb) chk($sformatf("tbl%0d errb", i), errb0, tbl[i].kb);
      if (tbl[i].ca) chk($sformatf("tbl%0d doa", i), doa0, tbl[i].xa);
      if (tbl[i].cb) chk($sformatf("tbl%0d dob", i), dob0, tbl[i].xb);
`ifdef DP_BRAM_COLLISION_DET_EN
      chk($sformatf("tbl%0d coll", i), coll0, tbl[i].kc);
`endif
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
`ifdef DP_BRAM_COLLISION_DET_EN
    chk("tbl coll_cnt0", cnt0, 3);
    chk("tbl coll_cnt1", cnt1, 3);
`endif

    // Same-port read-during-write on both configurations; row 0x10 currently holds 0xCAFEF00D.
    drive(1, 4'hF, 32'h10, 32'h11223344, 0, 0, 0, 0);
    tick();
    chk("rdw doa0 first", doa0, 32'hCAFEF00D);
    chk("rdw vala1 early", vala1, 0);
    drive(1, 4'h2, 32'h10, 32'h0000AA00, 0, 0, 0, 0);
    tick();
    chk("rdw doa0 read-first", doa0, 32'h11223344);
    chk("rdw vala1 lat2", vala1, 1);
    chk("rdw doa1 full", doa1, 32'h11223344);
    drive(0, 0, 0, 0, 1, 4'h0, 32'h10, 0);
    tick();
    chk("rdw vala0 idle", vala0, 0);
    chk("rdw doa0 hold", doa0, 32'h11223344);
    chk("rdw dob0 merged", dob0, 32'h1122AA44);
    chk("rdw doa1 write-first", doa1, 32'h1122AA44);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rdw vala1 drop", vala1, 0);
    chk("rdw doa1 hold", doa1, 32'h1122AA44);
    chk("rdw valb1", valb1, 1);
    chk("rdw dob1", dob1, 32'h1122AA44);

    // Reset with a two-cycle read in flight: it must vanish, memory must survive.
    drive(0, 0, 0, 0, 1, 4'h0, 32'h10, 0);
    tick();
    chk("inflight valb1 pre", valb1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst dob0", dob0, 0);
    chk("arst dob1", dob1, 0);
    chk("arst doa1", doa1, 0);
    chk("arst valb1", valb1, 0);
    tick();
    chk("arst valb1 hold", valb1, 0);
    #2 rst = 1'b0;
    tick();
    chk("post-rst valb1", valb1, 0);
    chk("post-rst dob1", dob1, 0);
`ifdef DP_BRAM_COLLISION_DET_EN
    chk("post-rst coll_cnt0", cnt0, 0);
`endif
    drive(0, 0, 0, 0, 1, 4'h0, 32'h10, 0);
    tick();
    chk("first dob0", dob0, 32'h1122AA44);
    chk("first valb0", valb0, 1);
    chk("first valb1 early", valb1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("first valb1", valb1, 1);
    chk("first dob1", dob1, 32'h1122AA44);
    tick();

    // Random traffic against the reference model, with rows 0..7 preloaded.
    for (int r = 0; r < 8; r++) rstep(1, 4'hF, 32'(r * 4), $urandom, 0, 4'h0, 32'h0, 32'h0);
    for (int n = 0; n < 1000; n++)
      rstep($urandom_range(0, 3) != 0, rand_we(), rand_addr(), $urandom,
            $urandom_range(0, 3) != 0, rand_we(), rand_addr(), $urandom);
    rstep(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    rstep(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
`ifdef DP_BRAM_COLLISION_DET_EN
    chk("rnd coll_cnt0", cnt0, 32'(ncoll));
    chk("rnd coll_cnt1", cnt1, 32'(ncoll));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_bram.md
DP_BRAM -- requirements
Module: dp_bram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8192, word count; power of two.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of row 0.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter RDW_MODE, default 0, same-port read-during-write behaviour; 0 = read-first, 1 = write-first.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports ena/enb, input, 1, port A/B access request this cycle.
REQ-009 SHALL have ports wea/web, input, DATA_W/8, per-byte write enables; ignored when en low.
REQ-010 SHALL have ports addra/addrb, input, 32, byte addresses.
REQ-011 SHALL have ports dia/dib, input, DATA_W, write data.
REQ-012 SHALL have ports doa/dob, output, DATA_W, read data.
REQ-013 SHALL have ports vala/valb, output, 1, doa/dob valid strobe.
REQ-014 SHALL have ports erra/errb, output, 1, out-of-range flag, qualified by vala/valb.

Function
REQ-015 Row SHALL be (addr - BASE_ADDR) >> log2(DATA_W/8); low byte-offset bits SHALL be ignored.
REQ-016 An access SHALL be in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*DATA_W/8.
REQ-017 An in-range access with byte enable i set SHALL write byte i of the row; other bytes SHALL be unchanged.
REQ-018 Every accepted access, read or write, SHALL perform a read and SHALL assert val exactly RD_LAT cycles after the en cycle, for one cycle.
REQ-019 Back-to-back accesses SHALL be accepted every cycle; no backpressure.
REQ-020 With RDW_MODE=0, do SHALL return the pre-write row contents; with RDW_MODE=1, do SHALL return the post-write row contents (merged bytes).
REQ-021 A cross-port read of a row written in the same cycle by the other port SHALL return the old contents.
REQ-022 When both ports write the same row in the same cycle, port A SHALL win on each byte where both enables are set; non-overlapping bytes SHALL both be written.
REQ-023 An out-of-range access SHALL suppress the write, SHALL return do = 0, and SHALL assert err with val.
REQ-024 do SHALL hold its last value while val is low.
REQ-025 With RD_LAT=2, a second output register stage SHALL be inserted, and val/err SHALL be pipelined alongside the data.

Reset
REQ-026 rst SHALL asynchronously clear do, val, err and all pipeline stages to 0.
REQ-027 Memory contents SHALL NOT be affected by rst; accesses in flight at reset SHALL be dropped with no val.
REQ-028 After rst deasserts, the first en cycle SHALL be accepted normally.

Configuration
REQ-029 With macro DP_BRAM_COLLISION_DET_EN defined, the block SHALL add output coll (1 bit) and output coll_cnt (16 bits).
REQ-030 coll SHALL pulse one cycle after any cycle with both ports enabled on the same in-range row and at least one port writing.
REQ-031 coll_cnt SHALL increment on each collision, SHALL saturate at 16'hFFFF, and SHALL be cleared by rst.
REQ-032 Without the macro, coll and coll_cnt SHALL not exist and no collision logic SHALL be synthesised.

Structure
REQ-033 The shared package SHALL hold the RDW_MODE encodings (READ_FIRST = 0, WRITE_FIRST = 1) and a clog2 helper.
REQ-034 One sub-module, dp_bram_port, SHALL implement a port's range check, row decode and output pipeline; it SHALL be instantiated twice.
REQ-035 The memory array SHALL remain in the top level so that it infers true dual-port block RAM.

Verification
REQ-036 Write A addr 0x10, wea=4'hF, dia=0xDEADBEEF; read B addr 0x10 -> dob=0xDEADBEEF, valb asserted RD_LAT cycles after the read cycle.
REQ-037 Row 0x10 holds 0x11223344; A write wea=4'b0010, dia=0x0000AA00 -> row reads 0x1122AA44; same-cycle doa = 0x11223344 (RDW_MODE=0) or 0x1122AA44 (RDW_MODE=1).
REQ-038 A and B both write row 0x20, wea=4'hF dia=0xAAAAAAAA, web=4'hF dib=0x55555555 -> readback 0xAAAAAAAA; with macro, coll pulses and coll_cnt=1.
REQ-039 Read at BASE_ADDR + DEPTH*4 -> doa=0, erra=1 with vala; a write to the same address -> memory unchanged.
REQ-040 Assert rst with an RD_LAT=2 read in flight -> no val ever appears for it, and do=0; memory retains prior data.
REQ-041 Run 1000 random cycles on both ports against a reference model -> zero data mismatches; coll_cnt equals the model's collision count.
